pcie_ss_axis_wrr_mux: RTL
=========================

Name: pcie_ss_axis_wrr_mux

Overview:
- Packet-aware N-channel AXI-S merge toward one PCIe SS stream, with a weighted round-robin arbiter.
- Successor to the fixed two-channel rxreq/commit mux: NUM_CH is parameterised, each channel has a runtime weight and enable, and the output is registered.
- Sits per link, between the producers (RXREQ, local write commits, future sources) and the AFU-facing rxreq port.

Parameters:
- NUM_CH, 4, number of sink channels (2..8).
- DATA_W, 512, tdata width; tkeep width is DATA_W/8.
- USER_W, 10, tuser_vendor width.
- WEIGHT_W, 4, width of each per-channel weight field.

Ports:
- clk  in  1  fim_clk domain clock.
- rst  in  1  asynchronous reset, active-high.
- sink_tvalid  in  NUM_CH  per-channel valid.
- sink_tready  out  NUM_CH  per-channel ready.
- sink_tdata  in  NUM_CH*DATA_W  channel c occupies slice [c*DATA_W +: DATA_W].
- sink_tkeep  in  NUM_CH*DATA_W/8  per-channel keep.
- sink_tlast  in  NUM_CH  end of packet.
- sink_tuser  in  NUM_CH*USER_W  tuser_vendor.
- ch_weight  in  NUM_CH*WEIGHT_W  packets per turn; 0 means the channel is masked.
- source_tvalid  out  1  merged valid.
- source_tready  in  1  downstream ready.
- source_tdata / source_tkeep / source_tlast / source_tuser  out  DATA_W / DATA_W/8 / 1 / USER_W  merged beat.
- cur_ch  out  $clog2(NUM_CH)  channel owning the current or last packet.
- pkt_locked  out  1  high while a multi-beat packet is in progress.

Behaviour:
- Reset (rst=1, asynchronous):
  - source_tvalid=0, source_tlast=0, pkt_locked=0, cur_ch=0, sink_tready=0.
  - rr_ptr=0; all credit counters=0.
  - Data registers are don't-care.
- Output register:
  - load = ~source_tvalid | source_tready.
  - A beat is accepted on channel c when sink_tvalid[c] & sink_tready[c]. It appears on source_* the next cycle (latency 1).
  - Throughput is one beat per clock with no bubbles, both within a packet and between back-to-back packets.
- sink_tready[c] = load & grant[c]. At most one bit of sink_tready is high in any cycle.
- FSM states:
  - ARB: grant is computed combinationally from eligible requests (sink_tvalid[c] & ch_weight[c]!=0), searching from rr_ptr.
    - Accepted beat with tlast=0: go to LOCK and hold the grant.
    - Accepted beat with tlast=1: stay in ARB.
  - LOCK: grant is fixed to cur_ch; ch_weight changes are ignored.
    - Stays in LOCK until a beat with tlast=1 is accepted, then returns to ARB.
    - pkt_locked = (state==LOCK).
- Weighted round-robin:
  - On the first beat of a packet from channel c:
    - If credit[c]==0, reload credit[c] = ch_weight[c] - 1.
    - Otherwise decrement credit[c].
  - At packet end (tlast accepted):
    - If credit[c]==0 afterwards, rr_ptr = c+1, wrapping to 0 after NUM_CH-1.
    - Otherwise rr_ptr = c, so the channel keeps priority for its next packet.
  - A channel that goes idle (tvalid=0 while it holds rr_ptr in ARB) forfeits its remaining credit. credit=0 and the pointer advances, so an idle channel cannot stall others.
- Weight rules:
  - ch_weight is sampled only at packet start.
  - Setting a weight to 0 mid-packet does not cut that packet; the channel is masked from the next arbitration onward.
- Boundaries:
  - No eligible requests: no grant, state stays ARB, rr_ptr unchanged.
  - All weights 0: no grants at all; source drains, then stays idle.
  - source_tready held low: the output register holds its beat, all sink_tready=0, and no state changes.
  - Single-beat packets from all channels every cycle: grants rotate by weight, one packet per clock.
  - rst asserted mid-packet: the partial packet is dropped on both sides. The bench must reset the producers too.

Decomposition:
- Add to pcie_ss_axis_pkg:
  - localparam PCIE_SS_WRR_MAX_CH = 8.
  - typedef t_wrr_state {ARB, LOCK}.
- One sub-module, pcie_ss_wrr_arbiter: weighted round-robin grant, credit counters and rr_ptr.
- The top level owns the FSM, the data mux and the output register.

Test Plan:
- NUM_CH=4, weights all 1, each channel streams 1-beat packets continuously → output channel order 0,1,2,3,0,…; 100% source_tvalid duty.
- Weights {3,1,1,1}, all channels saturated with 1-beat packets → per 6 packets: ch0×3, ch1, ch2, ch3; repeating.
- Ch1 sends a 4-beat packet while ch0/ch2 are valid → four consecutive ch1 beats; pkt_locked high for beats 1–3; no interleave.
- source_tready toggled 1010… during a 3-beat packet → no beat lost or duplicated; sink_tready high only on cycles where load=1.
- ch_weight[2] set to 0 at beat 2 of a 5-beat ch2 packet → packet completes with 5 beats; ch2 is never granted afterwards.
- rst pulsed during beat 2 of a 4-beat packet → next cycle source_tvalid=0 and pkt_locked=0; after release, ch0 gets the first grant.

Source files
------------

// File: rtl/pcie_ss_axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_ss_axis_pkg
// Description : Shared types and constants for the PCIe SS AXI-S weighted
//               round-robin merge (channel limit, arbitration FSM states,
//               round-robin pointer helper).
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_ss_axis_pkg;

  // Largest channel count the merge is built and verified for.
  localparam int PCIE_SS_WRR_MAX_CH = 8;

  // ARB : choosing the next packet owner
  // LOCK: a multi-beat packet owns the output until its tlast is accepted
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } t_wrr_state;

  // Next channel index after idx, wrapping to 0 after n-1.
  function automatic int unsigned wrr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : pcie_ss_axis_pkg
`default_nettype wire

// File: rtl/pcie_ss_axis_wrr_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : pcie_ss_axis_wrr_mux_if
// Description : Multi-lane AXI-Stream bundle. Lane l occupies slice
//               [l*DATA_W +: DATA_W] of tdata (and matching slices of tkeep
//               and tuser). LANES=NUM_CH for the sink side, LANES=1 for the
//               merged source side.
// Signals     : tvalid/tready/tlast [LANES], tdata [LANES*DATA_W],
//               tkeep [LANES*DATA_W/8], tuser [LANES*USER_W]
// Modports    : master drives the beat, slave drives tready.
// Revision    : 1.0 - initial release
// ============================================================================
interface pcie_ss_axis_wrr_mux_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 512,
  parameter int USER_W = 10
) ();

  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES*DATA_W-1:0]     tdata;
  logic [LANES*(DATA_W/8)-1:0] tkeep;
  logic [LANES-1:0]            tlast;
  logic [LANES*USER_W-1:0]     tuser;

  modport master (
    output tvalid, tdata, tkeep, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tuser,
    output tready
  );

endinterface : pcie_ss_axis_wrr_mux_if
`default_nettype wire

// File: rtl/pcie_ss_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pcie_ss_wrr_arbiter
// Description : Weighted round-robin grant for the PCIe SS AXI-S merge.
//               Holds the round-robin pointer and one credit counter per
//               channel; credits count remaining packets in a channel's turn.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_valid         - per-channel tvalid
//               i_weight        - per-channel weight (0 = masked)
//               i_start         - first beat of a packet accepted on i_ch
//               i_end           - last beat of a packet accepted on i_ch
//               i_ch            - channel of the accepted beat
//               o_grant_vld/_ch - combinational grant from the pointer search
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_ss_wrr_arbiter
  import pcie_ss_axis_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 4,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic [NUM_CH-1:0]          i_valid,
  input  wire logic [NUM_CH*WEIGHT_W-1:0] i_weight,
  input  wire logic                       i_start,
  input  wire logic                       i_end,
  input  wire logic [CH_W-1:0]            i_ch,
  output logic                            o_grant_vld,
  output logic [CH_W-1:0]                 o_grant_ch
);

  logic [CH_W-1:0]     r_rr_ptr;
  logic [WEIGHT_W-1:0] r_credit [NUM_CH];

  logic [NUM_CH-1:0]   w_elig;
  logic [WEIGHT_W-1:0] w_ch_weight;
  logic [WEIGHT_W-1:0] w_cur_credit;
  logic [WEIGHT_W-1:0] w_start_credit;
  logic [WEIGHT_W-1:0] w_end_credit;
  int                  w_idx;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_elig
      assign w_elig[g] = i_valid[g] & (i_weight[g*WEIGHT_W +: WEIGHT_W] != '0);
    end
  endgenerate

  // First eligible channel at or after the pointer.
  always_comb begin
    o_grant_vld = 1'b0;
    o_grant_ch  = '0;
    w_idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!o_grant_vld && w_elig[w_idx]) begin
        o_grant_vld = 1'b1;
        o_grant_ch  = CH_W'(w_idx);
      end
    end
  end

  // A fresh turn reloads weight-1 (this packet uses one credit); a turn in
  // progress spends one more credit.
  assign w_ch_weight    = i_weight[i_ch*WEIGHT_W +: WEIGHT_W];
  assign w_cur_credit   = r_credit[i_ch];
  assign w_start_credit = (w_cur_credit == '0) ? (w_ch_weight - 1'b1) : (w_cur_credit - 1'b1);
  // Single-beat packets start and end together, so use the fresh value.
  assign w_end_credit   = i_start ? w_start_credit : w_cur_credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      for (int c = 0; c < NUM_CH; c++) r_credit[c] <= '0;
    end else begin
      if (i_start) begin
        // A grant that skips the pointer holder means it was idle or masked:
        // it forfeits whatever is left of its turn.
        if (i_ch != r_rr_ptr) r_credit[r_rr_ptr] <= '0;
        r_credit[i_ch] <= w_start_credit;
      end
      if (i_end) begin
        r_rr_ptr <= (w_end_credit == '0) ? CH_W'(wrr_wrap_inc(32'(i_ch), NUM_CH)) : i_ch;
      end
    end
  end

endmodule : pcie_ss_wrr_arbiter
`default_nettype wire

// File: rtl/pcie_ss_axis_wrr_mux.sv
`default_nettype none
// ============================================================================
// Module      : pcie_ss_axis_wrr_mux
// Description : Packet-aware NUM_CH-to-1 AXI-S merge with weighted
//               round-robin arbitration and a registered output stage.
//               One beat per clock, no bubbles between packets.
// Ports       : clk, rst      - fim_clk, asynchronous active-high reset
//               sink          - NUM_CH-lane AXI-S input (slave)
//               source        - merged single-lane AXI-S output (master)
//               i_ch_weight   - per-channel packets per turn, 0 masks
//               o_cur_ch      - channel owning the current or last packet
//               o_pkt_locked  - a multi-beat packet is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_ss_axis_wrr_mux
  import pcie_ss_axis_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 512,
  parameter int USER_W   = 10,
  parameter int WEIGHT_W = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  pcie_ss_axis_wrr_mux_if.slave           sink,
  pcie_ss_axis_wrr_mux_if.master          source,
  input  wire logic [NUM_CH*WEIGHT_W-1:0] i_ch_weight,
  output logic [$clog2(NUM_CH)-1:0]       o_cur_ch,
  output logic                            o_pkt_locked
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int KEEP_W = DATA_W / 8;

  generate
    if (NUM_CH < 2 || NUM_CH > PCIE_SS_WRR_MAX_CH) begin : g_bad_num_ch
      $error("pcie_ss_axis_wrr_mux: NUM_CH out of range");
    end
  endgenerate

  t_wrr_state          r_state;
  logic [CH_W-1:0]     r_cur_ch;
  logic                r_src_valid;
  logic                r_src_last;
  logic [DATA_W-1:0]   r_src_data;
  logic [KEEP_W-1:0]   r_src_keep;
  logic [USER_W-1:0]   r_src_user;

  logic                w_load;
  logic                w_in_lock;
  logic                w_arb_vld;
  logic [CH_W-1:0]     w_arb_ch;
  logic                w_gnt_vld;
  logic [CH_W-1:0]     w_gnt_ch;
  logic [NUM_CH-1:0]   w_sink_ready;
  logic                w_accept;
  logic                w_sel_last;

  // The output register can take a new beat when empty or draining.
  // Held off during reset so no producer sees a handshake then.
  assign w_load    = ~rst & (~r_src_valid | source.tready[0]);
  assign w_in_lock = (r_state == LOCK);

  pcie_ss_wrr_arbiter #(
    .NUM_CH   (NUM_CH),
    .WEIGHT_W (WEIGHT_W),
    .CH_W     (CH_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (sink.tvalid),
    .i_weight    (i_ch_weight),
    .i_start     (w_accept & ~w_in_lock),
    .i_end       (w_accept & w_sel_last),
    .i_ch        (w_gnt_ch),
    .o_grant_vld (w_arb_vld),
    .o_grant_ch  (w_arb_ch)
  );

  // Mid-packet the owner keeps the grant regardless of weights.
  assign w_gnt_vld = w_in_lock | w_arb_vld;
  assign w_gnt_ch  = w_in_lock ? r_cur_ch : w_arb_ch;

  always_comb begin
    w_sink_ready = '0;
    if (w_load && w_gnt_vld) w_sink_ready[w_gnt_ch] = 1'b1;
  end

  assign sink.tready = w_sink_ready;
  assign w_accept    = |(sink.tvalid & w_sink_ready);
  assign w_sel_last  = sink.tlast[w_gnt_ch];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB;
      r_cur_ch    <= '0;
      r_src_valid <= 1'b0;
      r_src_last  <= 1'b0;
    end else begin
      if (w_accept) r_cur_ch <= w_gnt_ch;
      case (r_state)
        ARB:     if (w_accept && !w_sel_last) r_state <= LOCK;
        LOCK:    if (w_accept &&  w_sel_last) r_state <= ARB;
        default: r_state <= ARB;
      endcase
      if (w_load) begin
        r_src_valid <= w_accept;
        r_src_last  <= w_accept & w_sel_last;
      end
    end
  end

  // Payload needs no reset; it is only observed alongside r_src_valid.
  always_ff @(posedge clk) begin
    if (w_load && w_accept) begin
      r_src_data <= sink.tdata[w_gnt_ch*DATA_W +: DATA_W];
      r_src_keep <= sink.tkeep[w_gnt_ch*KEEP_W +: KEEP_W];
      r_src_user <= sink.tuser[w_gnt_ch*USER_W +: USER_W];
    end
  end

  assign source.tvalid = r_src_valid;
  assign source.tlast  = r_src_last;
  assign source.tdata  = r_src_data;
  assign source.tkeep  = r_src_keep;
  assign source.tuser  = r_src_user;
  assign o_cur_ch      = r_cur_ch;
  assign o_pkt_locked  = w_in_lock;

endmodule : pcie_ss_axis_wrr_mux
`default_nettype wire
